// File: rtl/design67_stim_checker.sv
// Stimulus/compare harness around a golden/netlist pair: LFSR vectors, mismatch stats, first-fail snapshot.
// Optional DESIGN67_STOP_ON_FAIL_EN: first mismatch ends the run immediately.
module design67_stim_checker #(
  parameter int unsigned     WIDTH         = 32,
  parameter int unsigned     NUM_VECTORS   = 1000,
  parameter int unsigned     SETTLE_CYCLES = 2,
  parameter int unsigned     RST_CYCLES    = 2,
  parameter logic [WIDTH-1:0] SEED         = 32'h0000_0001,
  parameter logic [WIDTH-1:0] POLY         = 32'h8020_0003
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_rst,
  output logic [WIDTH-1:0] stim_out,
  input  logic [WIDTH-1:0] golden_in,
  input  logic [WIDTH-1:0] netlist_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      mismatch_count,
  output logic [15:0]      first_fail_idx,
  output logic [WIDTH-1:0] first_fail_golden,
  output logic [WIDTH-1:0] first_fail_netlist
);

  typedef enum logic [2:0] {
    IDLE,
    DUTRST,
    RSTCMP,
    SLOT,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [15:0]      idx;
  logic [WIDTH-1:0] lfsr;

  logic             mis;
  logic             last;
  logic             stop;
  logic             cmp_edge;
  logic [15:0]      cnt_inc;
  logic [WIDTH-1:0] lfsr_nxt;

  assign mis      = golden_in != netlist_in;
  assign last     = idx == 16'(NUM_VECTORS);
  assign cmp_edge = (state == RSTCMP) ||
                    (cnt == 4'(SETTLE_CYCLES));
  assign cnt_inc  = (mismatch_count == 16'hFFFF) ?
                    mismatch_count : mismatch_count + 16'd1;
  assign lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? POLY : '0);

`ifdef DESIGN67_STOP_ON_FAIL_EN
  assign stop = last || mis;
`else
  assign stop = last;
`endif

  // The sample edge of one slot is also the launch edge of the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      idx                <= '0;
      lfsr               <= SEED;
      dut_rst            <= 1'b1;
      stim_out           <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      mismatch_count     <= '0;
      first_fail_idx     <= 16'hFFFF;
      first_fail_golden  <= '0;
      first_fail_netlist <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state              <= DUTRST;
            cnt                <= '0;
            idx                <= '0;
            lfsr               <= SEED;
            dut_rst            <= 1'b1;
            stim_out           <= '0;
            busy               <= 1'b1;
            done               <= 1'b0;
            pass               <= 1'b0;
            mismatch_count     <= '0;
            first_fail_idx     <= 16'hFFFF;
            first_fail_golden  <= '0;
            first_fail_netlist <= '0;
          end
        end
        DUTRST: begin
          if (cnt == 4'(RST_CYCLES - 1)) begin
            state <= RSTCMP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RSTCMP, SLOT: begin
          if (cmp_edge) begin
            if (mis) begin
              mismatch_count <= cnt_inc;
              if (mismatch_count == 16'd0) begin
                first_fail_idx     <= idx;
                first_fail_golden  <= golden_in;
                first_fail_netlist <= netlist_in;
              end
            end
            if (stop) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= !mis && (mismatch_count == 16'd0);
            end else begin
              state    <= SLOT;
              dut_rst  <= 1'b0;
              stim_out <= lfsr;
              lfsr     <= lfsr_nxt;
              idx      <= idx + 16'd1;
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_design67_stim_checker.sv
// Directed bench for design67_stim_checker: timing, LFSR sequence,
// mismatch stats, mid-run reset, ignored start.
module tb_design67_stim_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        dut_rst;
  logic [31:0] stim_out;
  logic [31:0] golden_in;
  logic [31:0] netlist_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] mismatch_count;
  logic [15:0] first_fail_idx;
  logic [31:0] first_fail_golden;
  logic [31:0] first_fail_netlist;

  int checks = 0;
  int failures = 0;
  int mode = 0;
  int n;
  logic [31:0] stim_log [0:255];
  logic        rst_log  [0:255];

  always #5 clk = ~clk;

  design67_stim_checker #(
    .WIDTH(32),
    .NUM_VECTORS(4),
    .SETTLE_CYCLES(2),
    .RST_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dut_rst(dut_rst),
    .stim_out(stim_out),
    .golden_in(golden_in),
    .netlist_in(netlist_in),
    .busy(busy),
    .done(done),
    .pass(pass),
    .mismatch_count(mismatch_count),
    .first_fail_idx(first_fail_idx),
    .first_fail_golden(first_fail_golden),
    .first_fail_netlist(first_fail_netlist)
  );

  always_comb begin
    golden_in  = stim_out ^ 32'h5A5A_0F0F;
    netlist_in = golden_in;
    if (mode == 1 && stim_out == 32'h8020_0003)
      netlist_in = golden_in ^ 32'h1;
    else if (mode == 2)
      netlist_in = golden_in + 32'h1;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run(input bit poke, input int stop_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    stim_log[0] = stim_out;
    rst_log[0]  = dut_rst;
    while (!done && n < 200 && n < stop_at) begin
      @(posedge clk);
      #1;
      n++;
      if (poke && n == 5) start = 1'b1;
      if (poke && n == 6) start = 1'b0;
      stim_log[n] = stim_out;
      rst_log[n]  = dut_rst;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_dut_rst"}, 32'(dut_rst), 32'd1);
    check({tag, "_stim"}, stim_out, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_count"}, 32'(mismatch_count), 32'd0);
    check({tag, "_idx"}, 32'(first_fail_idx), 32'hFFFF);
    check({tag, "_snap_g"}, first_fail_golden, 32'd0);
    check({tag, "_snap_n"}, first_fail_netlist, 32'd0);
  endtask

  initial begin
    #12;
    check_reset_vals("reset");
    rst = 1'b1;

    // Clean run: timing, sequence, dut_rst window
    mode = 0;
    run(1'b0, 1000);
    check("busy_after_start", 32'(rst_log[0]), 32'd1);
    check("t1_done_cycles", 32'(n), 32'd15);
    check("t1_pass", 32'(pass), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_count", 32'(mismatch_count), 32'd0);
    check("t1_idx", 32'(first_fail_idx), 32'hFFFF);
    check("dut_rst_c1", 32'(rst_log[1]), 32'd1);
    check("dut_rst_c2", 32'(rst_log[2]), 32'd1);
    check("dut_rst_c3", 32'(rst_log[3]), 32'd0);
    check("stim_c2", stim_log[2], 32'h0000_0000);
    check("stim_v1", stim_log[3], 32'h0000_0001);
    check("stim_v2", stim_log[6], 32'h8020_0003);
    check("stim_v3", stim_log[9], 32'hC030_0002);
    check("t1_done_dutrst", 32'(dut_rst), 32'd0);

    // Single mismatch on vector index 2
    mode = 1;
    run(1'b0, 1000);
`ifdef DESIGN67_STOP_ON_FAIL_EN
    check("t2_done_cycles", 32'(n), 32'd9);
`else
    check("t2_done_cycles", 32'(n), 32'd15);
`endif
    check("t2_count", 32'(mismatch_count), 32'd1);
    check("t2_idx", 32'(first_fail_idx), 32'd2);
    check("t2_snap_g", first_fail_golden, 32'hDA7A_0F0C);
    check("t2_snap_n", first_fail_netlist, 32'hDA7A_0F0D);
    check("t2_pass", 32'(pass), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_stable_count", 32'(mismatch_count), 32'd1);

    // Permanent mismatch
    mode = 2;
    run(1'b0, 1000);
`ifdef DESIGN67_STOP_ON_FAIL_EN
    check("t3_done_cycles", 32'(n), 32'd3);
    check("t3_count", 32'(mismatch_count), 32'd1);
`else
    check("t3_done_cycles", 32'(n), 32'd15);
    check("t3_count", 32'(mismatch_count), 32'd5);
`endif
    check("t3_idx", 32'(first_fail_idx), 32'd0);
    check("t3_snap_g", first_fail_golden, 32'h5A5A_0F0F);
    check("t3_snap_n", first_fail_netlist, 32'h5A5A_0F10);
    check("t3_pass", 32'(pass), 32'd0);

    // Reset during vector 3
    run(1'b0, 10);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b1;
    mode = 0;
    run(1'b0, 1000);
    check("t4_done_cycles", 32'(n), 32'd15);
    check("t4_stim_v1", stim_log[3], 32'h0000_0001);
    check("t4_pass", 32'(pass), 32'd1);
    check("t4_count", 32'(mismatch_count), 32'd0);
    check("t4_idx", 32'(first_fail_idx), 32'hFFFF);

    // start while busy is ignored
    run(1'b1, 1000);
    check("t5_done_cycles", 32'(n), 32'd15);
    check("t5_stim_v2", stim_log[6], 32'h8020_0003);
    check("t5_stim_v3", stim_log[9], 32'hC030_0002);
    check("t5_pass", 32'(pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/design67_stim_checker.md
Name: design67_stim_checker

Overview:
- Self-checking harness stage wrapped around the design67_15_45_top golden/post-route pair.
- Upstream role: generates the DUT reset phase and a pseudo-random 32-bit stimulus stream.
- Downstream role: after a fixed settle window, consumes the golden and netlist outputs, compares them, and keeps mismatch statistics plus a first-failure snapshot.
- Synthesizable, so on-board equivalence runs use the same check sequence the simulation bench uses.

Parameters:
- WIDTH, 32: stimulus and compare width.
- NUM_VECTORS, 1000: number of random vectors after the reset phase (1..65534).
- SETTLE_CYCLES, 2: cycles from stimulus change to compare sample (1..15).
- RST_CYCLES, 2: cycles dut_rst is held high (1..15).
- SEED, 32'h0000_0001: LFSR load value; must be non-zero.
- POLY, 32'h8020_0003: Galois LFSR feedback mask.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse; accepted only in IDLE or DONE.
- dut_rst, output, 1: active-high reset driven to both DUTs.
- stim_out, output, WIDTH: stimulus to both DUTs.
- golden_in, input, WIDTH: golden model output.
- netlist_in, input, WIDTH: post-route netlist output.
- busy, output, 1: high from the cycle after start until DONE.
- done, output, 1: level, high in DONE.
- pass, output, 1: valid when done; 1 iff mismatch_count == 0.
- mismatch_count, output, 16: saturating mismatch count.
- first_fail_idx, output, 16: compare index of first mismatch; 16'hFFFF if none.
- first_fail_golden, output, WIDTH: golden_in captured at first mismatch.
- first_fail_netlist, output, WIDTH: netlist_in captured at first mismatch.

Behaviour:
- Reset (rst=0, async): state IDLE, dut_rst=1, stim_out=0, LFSR=SEED, busy=0, done=0, pass=0, mismatch_count=0, first_fail_idx=16'hFFFF, both snapshots 0.
- FSM states: IDLE, DUTRST, RSTCMP, SLOT, DONE.
- IDLE/DONE + start: clear all statistics and load LFSR=SEED, go to DUTRST. start in any other state is ignored.
- DUTRST: dut_rst=1, stim_out=0 for RST_CYCLES cycles, then RSTCMP.
- RSTCMP: one cycle; compare index 0 on reset-state outputs; dut_rst still 1. Then SLOT with vector index 1.
- SLOT: each vector takes exactly SETTLE_CYCLES+1 cycles.
  - First edge of the slot: dut_rst=0, stim_out<=LFSR, LFSR advances: next = (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
  - Last edge of the slot: sample golden_in and netlist_in.
  - So the first vector is SEED itself.
- Compare rule: mismatch when golden_in != netlist_in.
  - mismatch_count increments and saturates at 16'hFFFF.
  - On the first mismatch only, capture the index and both values; later mismatches leave the snapshot unchanged.
- After the compare of index NUM_VECTORS, go to DONE: done=1, busy=0, pass valid.
  - stim_out holds its last value; dut_rst stays 0.
- Timing: done rises RST_CYCLES+1+NUM_VECTORS*(SETTLE_CYCLES+1) cycles after the edge that samples start.
- Reset asserted mid-run aborts immediately to the reset values above.
- Statistics stay stable in DONE until the next accepted start.

Optional Feature:
- Macro: DESIGN67_STOP_ON_FAIL_EN.
- Defined: the first mismatch sends the FSM straight to DONE on the next edge, with pass=0 and mismatch_count=1. Remaining vectors are skipped.
- Undefined: all NUM_VECTORS+1 compares always run.

Test Plan:
- golden_in tied to netlist_in; NUM_VECTORS=4, SETTLE_CYCLES=2, RST_CYCLES=2; pulse start -> done high exactly 15 cycles after the start edge; pass=1, mismatch_count=0, first_fail_idx=16'hFFFF.
- Default SEED/POLY -> stim_out sequence is 32'h00000001, 32'h80200003, 32'hC0300002; dut_rst=1 for the first 3 busy cycles, then 0.
- netlist_in = golden_in ^ 32'h1 only while stim_out==32'h80200003 -> mismatch_count=1, first_fail_idx=2, snapshots hold those two values, pass=0.
- netlist_in permanently golden_in+1, NUM_VECTORS=4 -> mismatch_count=5, first_fail_idx=0. With DESIGN67_STOP_ON_FAIL_EN: done right after RSTCMP, count=1.
- rst pulled low during vector 3 -> all outputs at reset values at once. A new start then reruns from SEED with clean statistics.
- start pulsed while busy -> ignored; sequence and done timing unchanged.
